// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first.
// Define SERIAL_ADDSUB_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.
module serial_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_cap_q, b_cap_q;
  logic             sub_cap_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic             cout_q, busy_q, done_q;
  logic             fa_s, fa_c;

  assign fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_cap_q   <= '0;
      b_cap_q   <= '0;
      sub_cap_q <= 1'b0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      cout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_cap_q   <= data_a;
            b_cap_q   <= data_b;
            sub_cap_q <= sub;
            busy_q    <= 1'b1;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          a_sh_q  <= a_cap_q;
          b_sh_q  <= sub_cap_q ? ~b_cap_q : b_cap_q;
          carry_q <= sub_cap_q;
          res_q   <= '0;
          cout_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
          ovf_q   <= 1'b0;
`endif
          cnt_q   <= CntW'(WIDTH);
          state_q <= StShift;
        end
        StShift: begin
          res_q   <= {fa_s, res_q[WIDTH-1:1]};
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= fa_c;
          cnt_q   <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            cout_q  <= fa_c;
`ifdef SERIAL_ADDSUB_OVF_EN
            // carry_q is the carry into the MSB on this last step.
            ovf_q   <= carry_q ^ fa_c;
`endif
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sum  = res_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
